// File: rtl/fll_cfg_pkg.sv
// Shared definitions for the FLL configuration responder: register
// addresses, handshake FSM states and default register reset values.
package fll_cfg_pkg;

  // Register address map seen through the req/ack handshake
  localparam logic [1:0] FLL_ADDR_STATUS = 2'd0;
  localparam logic [1:0] FLL_ADDR_CFG1   = 2'd1;
  localparam logic [1:0] FLL_ADDR_CFG2   = 2'd2;
  localparam logic [1:0] FLL_ADDR_INTEG  = 2'd3;

  // Responder FSM: wait for request, execute once, hold ack until release
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ACK  = 2'd2
  } fll_state_e;

  // Default reset contents of the config registers
  localparam logic [31:0] FLL_CFG1_RST_DEF  = 32'h0000_0000;
  localparam logic [31:0] FLL_CFG2_RST_DEF  = 32'h0000_0000;
  localparam logic [31:0] FLL_INTEG_RST_DEF = 32'h0000_0000;

endpackage

// File: rtl/fll_sync_2ff.sv
// Generic two-flop synchronizer for bringing level signals into the FLL
// reference clock domain. Each bit is synchronized independently, so only
// use it for signals whose bits are not required to arrive together.
module fll_sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First stage may go metastable; second stage gives it a cycle to settle
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/fll_cfg_responder.sv
// FLL-side endpoint of the 4-phase configuration handshake. Synchronizes the
// request, performs exactly one register read or write per transaction and
// holds ack (with stable read data) until the initiator releases the request.
module fll_cfg_responder
  import fll_cfg_pkg::*;
#(
  parameter logic [31:0] CFG1_RST  = FLL_CFG1_RST_DEF,
  parameter logic [31:0] CFG2_RST  = FLL_CFG2_RST_DEF,
  parameter logic [31:0] INTEG_RST = FLL_INTEG_RST_DEF
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        fll_req,
  input  logic        fll_wrn,
  input  logic [1:0]  fll_add,
  input  logic [31:0] fll_data,
  output logic        fll_ack,
  output logic [31:0] fll_r_data,
  input  logic [31:0] status_i,
  output logic [31:0] cfg1_o,
  output logic [31:0] cfg2_o,
  output logic [31:0] integ_o,
  output logic        cfg1_upd_o,
  output logic        cfg2_upd_o,
  output logic        integ_upd_o
);

  fll_state_e  state_q;
  logic        req_s;
  logic        wrn_q;
  logic [1:0]  add_q;
  logic [31:0] data_q;
  logic        ack_q;
  logic [31:0] r_data_q;
  logic [31:0] cfg1_q, cfg2_q, integ_q;
  logic        cfg1_upd_q, cfg2_upd_q, integ_upd_q;
  logic [31:0] rd_mux_d;

  // Only the request crosses domains; wrn/add/data are stable once req_s is seen
  fll_sync_2ff #(
    .WIDTH(1)
  ) u_req_sync (
    .clk_i (HCLK),
    .srst_i(HRESET),
    .d_i   (fll_req),
    .q_o   (req_s)
  );

  // Read data source selected by the captured address; STATUS is live
  always_comb begin
    rd_mux_d = status_i;
    case (add_q)
      FLL_ADDR_STATUS: rd_mux_d = status_i;
      FLL_ADDR_CFG1:   rd_mux_d = cfg1_q;
      FLL_ADDR_CFG2:   rd_mux_d = cfg2_q;
      FLL_ADDR_INTEG:  rd_mux_d = integ_q;
      default:         rd_mux_d = status_i;
    endcase
  end

  // Handshake FSM with the register file and registered ack/read-data/pulses
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      wrn_q       <= 1'b0;
      add_q       <= 2'd0;
      data_q      <= 32'd0;
      ack_q       <= 1'b0;
      r_data_q    <= 32'd0;
      cfg1_q      <= CFG1_RST;
      cfg2_q      <= CFG2_RST;
      integ_q     <= INTEG_RST;
      cfg1_upd_q  <= 1'b0;
      cfg2_upd_q  <= 1'b0;
      integ_upd_q <= 1'b0;
    end else begin
      cfg1_upd_q  <= 1'b0;
      cfg2_upd_q  <= 1'b0;
      integ_upd_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_s) begin
            wrn_q   <= fll_wrn;
            add_q   <= fll_add;
            data_q  <= fll_data;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (wrn_q) begin
            r_data_q <= rd_mux_d;
          end else begin
            // STATUS is read-only: a write there is acked but has no effect
            case (add_q)
              FLL_ADDR_CFG1: begin
                cfg1_q     <= data_q;
                cfg1_upd_q <= 1'b1;
              end
              FLL_ADDR_CFG2: begin
                cfg2_q     <= data_q;
                cfg2_upd_q <= 1'b1;
              end
              FLL_ADDR_INTEG: begin
                integ_q     <= data_q;
                integ_upd_q <= 1'b1;
              end
              default: ;
            endcase
          end
          ack_q   <= 1'b1;
          state_q <= ST_ACK;
        end
        ST_ACK: begin
          if (!req_s) begin
            ack_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign fll_ack     = ack_q;
  assign fll_r_data  = r_data_q;
  assign cfg1_o      = cfg1_q;
  assign cfg2_o      = cfg2_q;
  assign integ_o     = integ_q;
  assign cfg1_upd_o  = cfg1_upd_q;
  assign cfg2_upd_o  = cfg2_upd_q;
  assign integ_upd_o = integ_upd_q;

endmodule
